dbf_beam_sum: RTL
=================

# dbf_beam_sum

Channel-serial beam accumulator for the digital beamformer. It sits directly downstream of the per-channel complex weighting cell. It sums N_CH consecutive weighted channel samples (33-bit I/Q) into one beam sample, then scales, saturates and narrows the result to 16-bit I/Q for the range/Doppler processing chain.

## Interface
Parameters:
- N_CH, 8: channels summed per beam sample (2..64).
- IN_W, 33: input I/Q width, signed two's complement.
- OUT_W, 16: output I/Q width, signed.
- SHIFT, 17: arithmetic right shift applied to the accumulated sum (1..IN_W).

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din_I, input, IN_W: weighted channel sample, in-phase.
- din_Q, input, IN_W: weighted channel sample, quadrature.
- din_valid, input, 1: din_I/din_Q valid this cycle. There is no backpressure; the block always accepts.
- din_first, input, 1: qualifies a valid sample as channel 0 of a new snapshot.
- dout_I, output, OUT_W: beam sample, in-phase.
- dout_Q, output, OUT_W: beam sample, quadrature.
- dout_valid, output, 1: one-cycle pulse per completed beam sample.
- dout_sat, output, 1: I or Q saturated in this output (valid with dout_valid).
- err_frame, output, 1: one-cycle pulse on a framing error.

## Operation
- Accumulator width is AW = IN_W + clog2(N_CH) (36 by default). Inputs are sign-extended to AW; the accumulator never overflows.
- Channel counter cnt runs 0..N_CH-1. cnt = 0 means idle (no frame open).
- Accepted sample with din_first=1:
  - acc <= din and cnt <= 1.
  - If cnt ≠ 0, the open frame is discarded and err_frame pulses.
- Accepted sample with din_first=0 and cnt ≠ 0: acc <= acc + din and cnt <= cnt + 1.
- Accepted sample with din_first=0 and cnt = 0: the sample is dropped and err_frame pulses.
- Completion: when the accepted sample is the N_CH-th of its frame (N_CH=1 is not supported):
  - The final sum is latched into the scale stage.
  - cnt returns to 0.
- Scale stage, applied to I and Q independently:
  - s = acc >>> SHIFT (arithmetic shift; floor toward −inf, no rounding).
  - s is then narrowed to OUT_W bits; see Configuration.
- Gaps (din_valid=0) are allowed anywhere inside a frame. acc and cnt hold during gaps.
- There is no frame timeout.

## Timing
- Latency: if the last sample of a frame is accepted at edge t, the final sum is registered at t, scaled outputs are registered at t+1, and dout_valid is high for the cycle following edge t+1 (2-cycle latency).
- dout_I, dout_Q and dout_sat hold their values between pulses.
- Full throughput: din_first may arrive on the cycle immediately after a frame's last sample. A new frame may accumulate while the previous result is in the scale stage.
- err_frame is registered and asserts in the cycle after the offending sample.
- A din_first that aborts a frame produces no dout_valid for the aborted frame.
- Reset values: dout_I=0, dout_Q=0, dout_valid=0, dout_sat=0, err_frame=0, cnt=0, acc=0.
- Reset mid-frame discards the partial sum. A result already in the scale stage is discarded; no dout_valid follows the reset.
- If rst and din_valid are high in the same cycle, rst wins and the sample is dropped.

## Configuration
- Macro: DBF_BEAM_SAT_EN.
- Defined:
  - s is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - dout_sat = 1 when either I or Q clamped.
- Undefined:
  - s is truncated to its low OUT_W bits (wrap-around).
  - dout_sat is tied to 0.
- Default build defines DBF_BEAM_SAT_EN.

## Test plan
- Nominal (defaults): 8 contiguous samples, din_first on the first, each din_I=13107200 and din_Q=−13107200 -> one dout_valid exactly 2 cycles after the 8th sample, with dout_I=800, dout_Q=−800, dout_sat=0.
- Floor and gaps: 8 samples of din_I=−1, din_Q=0, with 3 idle cycles after the 2nd and 5th samples -> dout_I=−1, dout_Q=0, 2 cycles after the last sample.
- Saturation: 8 samples of din_I=2^32−1, din_Q=−2^32 -> with macro: dout_I=32767, dout_Q=−32768, dout_sat=1. Without macro: dout_I=−1 (0xFFFF), dout_Q=0, dout_sat=0.
- Framing:
  - din_first on the 5th sample of a frame -> err_frame pulse, no output for the aborted frame. The next 7 samples complete a new frame with the correct sum.
  - An orphan sample (din_first=0) while idle -> err_frame pulse, sample ignored.
- Back-to-back: 4 frames with no gaps (32 consecutive valid cycles) -> 4 dout_valid pulses spaced exactly 8 cycles apart, each with the correct sum.
- Reset: assert rst for 1 cycle after the 6th sample of a frame, then after the 8th sample of the next frame -> no dout_valid from either interrupted frame, all outputs 0. A following clean frame produces the correct output.

Source files
------------

// File: rtl/dbf_beam_sum.sv
// Channel-serial beam accumulator: sums N_CH weighted channel samples, then shifts and narrows.
// Optional feature macro: DBF_BEAM_SAT_EN (clamp on overflow, else wrap-around).
module dbf_beam_sum #(
    parameter int N_CH  = 8,
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int SHIFT = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  din_I,
    input  logic [IN_W-1:0]  din_Q,
    input  logic             din_valid,
    input  logic             din_first,
    output logic [OUT_W-1:0] dout_I,
    output logic [OUT_W-1:0] dout_Q,
    output logic             dout_valid,
    output logic             dout_sat,
    output logic             err_frame
);

    localparam int CW = $clog2(N_CH);
    localparam int AW = IN_W + CW;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_CH - 1);

    logic signed [AW-1:0] ext_I;
    logic signed [AW-1:0] ext_Q;
    logic signed [AW-1:0] acc_I;
    logic signed [AW-1:0] acc_Q;
    logic signed [AW-1:0] nxt_I;
    logic signed [AW-1:0] nxt_Q;
    logic signed [AW-1:0] sum_I;
    logic signed [AW-1:0] sum_Q;
    logic signed [AW-1:0] shr_I;
    logic signed [AW-1:0] shr_Q;
    logic [CW-1:0]        cnt;
    logic                 sum_valid;
    logic [OUT_W:0]       nar_I;
    logic [OUT_W:0]       nar_Q;

    // Returns {overflow_flag, narrowed_value}.
    function automatic logic [OUT_W:0] narrow(input logic signed [AW-1:0] s);
`ifdef DBF_BEAM_SAT_EN
        logic [AW-OUT_W:0] hi;
        hi = s[AW-1:OUT_W-1];
        if (hi == '0 || hi == '1)
            narrow = {1'b0, s[OUT_W-1:0]};
        else if (s[AW-1])
            narrow = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            narrow = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
`else
        narrow = {1'b0, s[OUT_W-1:0]};
`endif
    endfunction

    assign ext_I = {{CW{din_I[IN_W-1]}}, din_I};
    assign ext_Q = {{CW{din_Q[IN_W-1]}}, din_Q};
    assign nxt_I = acc_I + ext_I;
    assign nxt_Q = acc_Q + ext_Q;

    assign shr_I = sum_I >>> SHIFT;
    assign shr_Q = sum_Q >>> SHIFT;
    assign nar_I = narrow(shr_I);
    assign nar_Q = narrow(shr_Q);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_I     <= '0;
            acc_Q     <= '0;
            cnt       <= '0;
            sum_I     <= '0;
            sum_Q     <= '0;
            sum_valid <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            err_frame <= 1'b0;
            if (din_valid) begin
                if (din_first) begin
                    // A new channel 0 always wins; any open frame is lost.
                    acc_I     <= ext_I;
                    acc_Q     <= ext_Q;
                    cnt       <= CW'(1);
                    err_frame <= (cnt != '0);
                end else if (cnt == '0) begin
                    err_frame <= 1'b1;
                end else if (cnt == LAST_CNT) begin
                    acc_I     <= nxt_I;
                    acc_Q     <= nxt_Q;
                    sum_I     <= nxt_I;
                    sum_Q     <= nxt_Q;
                    sum_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc_I <= nxt_I;
                    acc_Q <= nxt_Q;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_I     <= '0;
            dout_Q     <= '0;
            dout_sat   <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= sum_valid;
            if (sum_valid) begin
                dout_I   <= nar_I[OUT_W-1:0];
                dout_Q   <= nar_Q[OUT_W-1:0];
                dout_sat <= nar_I[OUT_W] | nar_Q[OUT_W];
            end
        end
    end

endmodule
